// File: rtl/sr_trace_uart_tx.sv
// sr_trace_uart_tx
//   Instruction-trace transmitter for schoolRISCV. Each trace_valid strobe
//   (gated by en) captures one {pc, instr, a0} record into a small FIFO.
//   Every record goes out on a UART 8N1 line as a 13-byte frame:
//   SYNC_BYTE, then pc, instr and a0, each sent MSB byte first.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset; flushes FIFO, aborts frame
//   en           capture enable; trace_valid is ignored while low
//   trace_valid  pc/instr/a0 describe a retired instruction
//   trace_pc     program counter (32 bits)
//   trace_instr  instruction word (32 bits)
//   trace_a0     register x10 value (32 bits)
//   tx           UART serial output, idle high (registered)
//   busy         transmitter active or FIFO not empty
//   drop_cnt     saturating count of records lost to a full FIFO
`timescale 1ns/1ps

module sr_trace_uart_tx #(
  parameter int         CLKS_PER_BIT = 4,
  parameter int         DEPTH        = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_instr,
  input  logic [31:0] trace_a0,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]   LAST_TICK  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_next;

  logic [95:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            drop;

  logic [CW-1:0]   tick;
  logic            bit_done;
  logic [2:0]      bit_idx;
  logic [3:0]      byte_idx;
  logic [7:0]      shift;
  logic [95:0]     rec;

  // Full/empty come from the registered occupancy, so a push on the same
  // edge as a pop still sees the FIFO as it was before that edge.
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = en & trace_valid & ~fifo_full;
  assign drop       = en & trace_valid & fifo_full;
  assign bit_done   = (tick == LAST_TICK);
  assign busy       = (state != IDLE) | ~fifo_empty;

  // FIFO storage kept free of reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {trace_pc, trace_instr, trace_a0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte sequencing: a frame is 13 back-to-back bytes with no gap between
  // a stop bit and the following start bit.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = (byte_idx == 4'd12) ? IDLE : START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The popped record lives in rec and is consumed a byte at a time from
  // its top; shift holds the byte on the wire and is emptied LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '1;
      rec      <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick <= '0;
          if (pop) begin
            rec      <= mem[rd_ptr];
            shift    <= SYNC_BYTE;
            byte_idx <= '0;
          end
        end
        START: begin
          tick <= bit_done ? '0 : tick + 1'b1;
          if (bit_done) begin
            bit_idx <= '0;
          end
        end
        DATA: begin
          tick <= bit_done ? '0 : tick + 1'b1;
          if (bit_done) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          tick <= bit_done ? '0 : tick + 1'b1;
          if (bit_done && (byte_idx != 4'd12)) begin
            byte_idx <= byte_idx + 1'b1;
            shift    <= rec[95:88];
            rec      <= {rec[87:0], 8'h00};
          end
        end
        default: tick <= '0;
      endcase
    end
  end

  // tx is registered, so the line lags the state register by one cycle;
  // this gives push-to-start-bit latency of two edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
